image_cam_matcher: RTL and testbench
====================================

Name: image_cam_matcher

Overview:
- Multi-slot image content-addressable memory. Stores up to NO_OF_IMG pixel streams, then compares a query stream against every stored slot in parallel.
- Reports a per-slot match vector plus the lowest-index hit.
- Successor to the two-image CAM:
  - parametrised slot count;
  - command and pixel valid/ready handshakes;
  - per-slot stored length;
  - slot invalidate.
- Sits between the BMP pixel streamer and the host result logic.

Parameters:
- ADDR_WIDTH, 15, pixel address width; slot depth is 2**ADDR_WIDTH pixels.
- DATA_WIDTH, 24, pixel width (B,G,R bytes, LSB = B).
- NO_OF_IMG, 4, number of image slots, >=2.
- SEL_WIDTH, $clog2(NO_OF_IMG), slot select width (derived).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 load, 01 search, 10 invalidate, 11 reserved (accepted, no-op)
- cmd_sel  in  SEL_WIDTH  target slot for load/invalidate
- cmd_len  in  ADDR_WIDTH+1  pixel count for load/search
- px_valid  in  1  pixel valid
- px_ready  out  1  high in LOAD/SEARCH while remaining count > 0
- px_data  in  DATA_WIDTH  pixel
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse at command completion
- match  out  NO_OF_IMG  per-slot match result of last search
- match_any  out  1  OR of match
- match_idx  out  SEL_WIDTH  lowest set bit of match, 0 if none

Behaviour:
- Reset values (async assert, sync deassert by user):
  - state=IDLE;
  - cmd_ready=0 during reset, 1 after;
  - px_ready=0, busy=0, done=0;
  - match=0, match_any=0, match_idx=0;
  - slot_valid=0 and slot_len=0 for all slots.
  - Memory contents are not cleared.
- FSM states and transitions:
  - IDLE: cmd_valid&cmd_ready accepts the command and latches op/sel/len; cnt=0.
    - op=00 -> LOAD.
    - op=01 -> SEARCH. Cleared to 0 in this cycle: match, match_any, match_idx. Initialised: cand[k] = slot_valid[k] & (slot_len[k]==cmd_len).
    - op=10 -> FINISH; slot_valid[sel]=0.
    - op=11 -> FINISH.
    - len==0 for load/search -> FINISH directly.
  - LOAD: each px_valid&px_ready writes mem[sel][cnt]=px_data; cnt++.
    - When cnt reaches len: slot_len[sel]=len, slot_valid[sel]=1 -> FINISH.
    - slot_valid[sel] is cleared on entry to LOAD, so a partially loaded slot never matches.
  - SEARCH: stage 1 registers the accepted pixel and cnt. Stage 2 sets cand[k] &= (mem[k][cnt_r]==px_r) for all k. The memory read is registered, aligned with stage 2.
    - After the last pixel is accepted: DRAIN (1 cycle) -> FINISH.
  - FINISH: done=1 for one cycle.
    - Search: match=cand, match_any=|cand, match_idx = priority encode (lowest index wins).
    - Load with len==0: slot_valid[sel]=1, slot_len[sel]=0.
    - Next state IDLE.
- Latency:
  - Search: done and match update 3 cycles after the last pixel handshake. len==0 search: done 1 cycle after the command.
  - Load: done 1 cycle after the last pixel handshake.
- Handshakes:
  - Transfer occurs only when valid&ready.
  - px_valid in IDLE is ignored.
  - cmd_valid during busy is held off (cmd_ready=0).
- Boundaries:
  - cmd_len > 2**ADDR_WIDTH is saturated to 2**ADDR_WIDTH.
  - cnt never wraps.
  - Searching with no valid slots -> match=0, match_idx=0, match_any=0.
  - Multiple hits -> all bits set, match_idx=lowest.
- Reset asserted mid-LOAD/SEARCH:
  - immediate return to IDLE;
  - slot valid bits and match cleared;
  - no done pulse.
- match holds its value until the next search command is accepted.

Optional Feature:
- Macro PIXEL_TOL_EN.
- Defined:
  - adds input port tol (8 bits);
  - a pixel matches when each 8-bit channel satisfies |stored - query| <= tol;
  - tol is sampled at search command acceptance.
- Undefined:
  - exact equality compare only;
  - no tol port.

Decomposition:
- Package image_cam_pkg holds:
  - op encodings (OP_LOAD, OP_SEARCH, OP_INVAL, OP_RSVD);
  - FSM state typedef (IDLE, LOAD, SEARCH, DRAIN, FINISH);
  - channel width constant 8.
- Sub-module cam_slot: one slot's memory, valid/len registers and running candidate bit. Instantiated NO_OF_IMG times via generate. The top holds the FSM and the priority encoder.

Test Plan:
- Load slot0 with 4 pixels {0x0000FF,0x00FF00,0xFF0000,0x123456}. Load slot2 with 4 different pixels. Search the slot0 sequence -> done, match=4'b0001, match_idx=0, match_any=1.
- Load slot1 identical to slot0. Search -> match=4'b0011, match_idx=0. Invalidate slot0, search again -> match=4'b0010, match_idx=1.
- Search slot0 data with cmd_len=3 (length mismatch) -> match=0, match_any=0.
- Random px_valid gaps and backpressure during load and search of 16 pixels -> identical results to the gap-free run; done exactly 3 cycles after the last search handshake.
- Assert reset for 1 cycle mid-search after 2 of 4 pixels -> busy=0, no done, match=0; next search with no reloaded slots -> match=0.
- With PIXEL_TOL_EN, tol=2: stored 0x101010, query 0x121010 -> match; query 0x131010 -> no match.

Source files
------------

// File: rtl/image_cam_matcher_pkg.sv
// Shared definitions for the multi-slot image CAM: command encodings, FSM states, channel width.
// The optional per-channel tolerance compare is enabled by the PIXEL_TOL_EN macro.
package image_cam_pkg;

    localparam int CH_W = 8;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SEARCH = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEARCH,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/image_cam_matcher_if.sv
// Command and pixel stream bundle between the pixel streamer (master) and the CAM (slave).
// Both channels transfer exactly when valid & ready are high at a rising clock edge; valid never waits on ready.
interface image_cam_matcher_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 24,
    parameter int SEL_WIDTH  = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [SEL_WIDTH-1:0]  cmd_sel;
    logic [ADDR_WIDTH:0]   cmd_len;
    logic                  px_valid;
    logic                  px_ready;
    logic [DATA_WIDTH-1:0] px_data;

    modport master (
        output cmd_valid, cmd_op, cmd_sel, cmd_len, px_valid, px_data,
        input  cmd_ready, px_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sel, cmd_len, px_valid, px_data,
        output cmd_ready, px_ready
    );
endinterface

// File: rtl/image_cam_matcher_cam_slot.sv
// One CAM slot: pixel memory, registered read port, valid/length registers and the running candidate bit.
// With PIXEL_TOL_EN defined each 8-bit channel may differ by up to i_tol; otherwise exact equality.
module cam_slot
    import image_cam_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr_valid,
    input  logic                  i_commit,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_cand_init,
    input  logic                  i_init_hit,
    input  logic                  i_cmp_en,
    input  logic [DATA_WIDTH-1:0] i_cmp_px,
`ifdef PIXEL_TOL_EN
    input  logic [CH_W-1:0]       i_tol,
`endif
    output logic                  o_valid,
    output logic [ADDR_WIDTH:0]   o_len,
    output logic                  o_cand
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd;
    logic                  r_valid;
    logic                  r_cand;
    logic [ADDR_WIDTH:0]   r_len;
    logic                  w_px_hit;

    // Memory contents survive reset; only the bookkeeping registers are cleared.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_addr] <= i_wr_data;
        if (i_rd_en) r_rd <= r_mem[i_addr];
    end

`ifdef PIXEL_TOL_EN
    localparam int NCH = DATA_WIDTH / CH_W;
    logic [CH_W-1:0] w_a, w_b, w_d;

    always_comb begin
        w_px_hit = 1'b1;
        w_a      = '0;
        w_b      = '0;
        w_d      = '0;
        for (int c = 0; c < NCH; c++) begin
            w_a = r_rd[c*CH_W +: CH_W];
            w_b = i_cmp_px[c*CH_W +: CH_W];
            w_d = (w_a > w_b) ? (w_a - w_b) : (w_b - w_a);
            if (w_d > i_tol) w_px_hit = 1'b0;
        end
    end
`else
    assign w_px_hit = (r_rd == i_cmp_px);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_len   <= '0;
            r_cand  <= 1'b0;
        end else begin
            if (i_clr_valid) begin
                r_valid <= 1'b0;
            end else if (i_commit) begin
                r_valid <= 1'b1;
                r_len   <= i_len;
            end
            if (i_cand_init) r_cand <= i_init_hit;
            else if (i_cmp_en) r_cand <= r_cand & w_px_hit;
        end
    end

    assign o_valid = r_valid;
    assign o_len   = r_len;
    assign o_cand  = r_cand;

endmodule

// File: rtl/image_cam_matcher.sv
// Multi-slot image CAM top: command FSM, search pixel stage, per-slot instances and lowest-index encoder.
// Defining PIXEL_TOL_EN adds the 8-bit tol port, sampled when a search command is accepted.
module image_cam_matcher
    import image_cam_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 24,
    parameter int NO_OF_IMG  = 4,
    parameter int SEL_WIDTH  = $clog2(NO_OF_IMG)
) (
    input  logic                 clk,
    input  logic                 reset,
    image_cam_matcher_if.slave   bus,
`ifdef PIXEL_TOL_EN
    input  logic [CH_W-1:0]      tol,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [NO_OF_IMG-1:0] match,
    output logic                 match_any,
    output logic [SEL_WIDTH-1:0] match_idx,
    output state_t               dbg_state
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);

    state_t                  r_state, w_next;
    logic [1:0]              r_op;
    logic [SEL_WIDTH-1:0]    r_sel;
    logic [ADDR_WIDTH:0]     r_len, r_cnt, w_cnt_inc, w_len_sat;
    logic [DATA_WIDTH-1:0]   r_px;
    logic                    r_s1v;
    logic [NO_OF_IMG-1:0]    r_match;
    logic                    w_cmd_ready, w_px_ready, w_cmd_fire, w_px_fire;
    logic                    w_clr, w_commit, w_wr, w_rd, w_init;
    logic [NO_OF_IMG-1:0]    w_valid, w_cand, w_init_hit;
    logic [ADDR_WIDTH:0]     w_len [NO_OF_IMG];
`ifdef PIXEL_TOL_EN
    logic [CH_W-1:0]         r_tol;
`endif

    assign w_len_sat  = (bus.cmd_len > DEPTH) ? DEPTH : bus.cmd_len;
    assign w_cnt_inc  = r_cnt + ONE;
    assign w_cmd_fire = bus.cmd_valid & w_cmd_ready;
    assign w_px_fire  = bus.px_valid & w_px_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // SEARCH lingers one cycle after the last pixel so the final compare lands before DRAIN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_cmd_fire) begin
                case (bus.cmd_op)
                    OP_LOAD:   w_next = (w_len_sat == '0) ? FINISH : LOAD;
                    OP_SEARCH: w_next = (w_len_sat == '0) ? FINISH : SEARCH;
                    default:   w_next = FINISH;
                endcase
            end
            LOAD:    if (w_px_fire && (w_cnt_inc == r_len)) w_next = FINISH;
            SEARCH:  if (r_cnt == r_len) w_next = DRAIN;
            DRAIN:   w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != IDLE);
        done        = (r_state == FINISH);
        w_cmd_ready = (r_state == IDLE) && reset;
        w_px_ready  = ((r_state == LOAD) || (r_state == SEARCH)) && (r_cnt < r_len);
        w_clr       = w_cmd_fire && ((bus.cmd_op == OP_LOAD) || (bus.cmd_op == OP_INVAL));
        w_commit    = (r_state == FINISH) && (r_op == OP_LOAD);
        w_wr        = (r_state == LOAD) && w_px_fire;
        w_rd        = (r_state == SEARCH) && w_px_fire;
        w_init      = w_cmd_fire && (bus.cmd_op == OP_SEARCH);
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.px_ready  = w_px_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= OP_LOAD;
            r_sel   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_px    <= '0;
            r_s1v   <= 1'b0;
            r_match <= '0;
`ifdef PIXEL_TOL_EN
            r_tol   <= '0;
`endif
        end else begin
            r_s1v <= w_rd;
            if (w_rd) r_px <= bus.px_data;
            if (w_cmd_fire) begin
                r_op  <= bus.cmd_op;
                r_sel <= bus.cmd_sel;
                r_len <= w_len_sat;
                r_cnt <= '0;
                // A zero-length search resolves immediately from the slot bookkeeping.
                if (bus.cmd_op == OP_SEARCH) begin
                    r_match <= (w_len_sat == '0) ? w_init_hit : '0;
`ifdef PIXEL_TOL_EN
                    r_tol   <= tol;
`endif
                end
            end else if (w_px_fire) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == DRAIN) r_match <= w_cand;
        end
    end

    for (genvar k = 0; k < NO_OF_IMG; k++) begin : g_slot
        assign w_init_hit[k] = w_valid[k] && (w_len[k] == w_len_sat);

        cam_slot #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst_n       (reset),
            .i_clr_valid (w_clr && (bus.cmd_sel == SEL_WIDTH'(k))),
            .i_commit    (w_commit && (r_sel == SEL_WIDTH'(k))),
            .i_len       (r_len),
            .i_wr_en     (w_wr && (r_sel == SEL_WIDTH'(k))),
            .i_rd_en     (w_rd),
            .i_addr      (r_cnt[ADDR_WIDTH-1:0]),
            .i_wr_data   (bus.px_data),
            .i_cand_init (w_init),
            .i_init_hit  (w_init_hit[k]),
            .i_cmp_en    (r_s1v),
            .i_cmp_px    (r_px),
`ifdef PIXEL_TOL_EN
            .i_tol       (r_tol),
`endif
            .o_valid     (w_valid[k]),
            .o_len       (w_len[k]),
            .o_cand      (w_cand[k])
        );
    end

    always_comb begin
        match_idx = '0;
        for (int k = NO_OF_IMG - 1; k >= 0; k--) begin
            if (r_match[k]) match_idx = SEL_WIDTH'(k);
        end
    end

    assign match     = r_match;
    assign match_any = |r_match;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_image_cam_matcher.sv
// Directed bench for image_cam_matcher with a small slot depth (16 pixels) so saturation is reachable.
// Searches push their expected match vector on exp_q and pop it when done is observed.
module tb_image_cam_matcher;
    import image_cam_pkg::*;

    localparam int AW = 4;
    localparam int DW = 24;
    localparam int NI = 4;
    localparam int SW = 2;

    logic            clk;
    logic            reset;
    logic            busy, done, match_any;
    logic [NI-1:0]   match;
    logic [SW-1:0]   match_idx;
    state_t          dbg_state;
    logic [7:0]      tol;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int hs_cyc    = 0;
    int done_cnt  = 0;
    logic [DW-1:0] buf_px [0:31];
    logic [NI-1:0] exp_q [$];

    image_cam_matcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    image_cam_matcher #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NO_OF_IMG  (NI),
        .SEL_WIDTH  (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
`ifdef PIXEL_TOL_EN
        .tol       (tol),
`endif
        .busy      (busy),
        .done      (done),
        .match     (match),
        .match_any (match_any),
        .match_idx (match_idx),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter / done monitor
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic send_cmd(input logic [1:0] op, input logic [SW-1:0] sel, input logic [AW:0] len);
        int b;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_sel   = sel;
        bus.cmd_len   = len;
        b = 0;
        while (bus.cmd_ready !== 1'b1 && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        hs_cyc = cyc;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic send_pixels(input int n, input bit gaps);
        int b;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            bus.px_valid = 1'b1;
            bus.px_data  = buf_px[i];
            b = 0;
            while (bus.px_ready !== 1'b1 && b < 20) begin
                @(negedge clk);
                b++;
            end
            chk("px_ready_wait", bus.px_ready, 1);
            hs_cyc = cyc;
            @(posedge clk);
            #1 bus.px_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int b;
        b = 0;
        @(negedge clk);
        while (done !== 1'b1 && b < 40) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_lat"}, cyc - hs_cyc, exp_lat);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
    endtask

    task automatic do_load(input string tag, input logic [SW-1:0] sel, input int n,
                           input logic [AW:0] len, input bit gaps);
        send_cmd(OP_LOAD, sel, len);
        if (n > 0) send_pixels(n, gaps);
        wait_done(tag, 1);
    endtask

    // scoreboard: expected match queued at issue, compared when the command completes
    task automatic do_search(input string tag, input int n, input logic [AW:0] len,
                             input logic [NI-1:0] exp_m, input logic [SW-1:0] exp_idx, input bit gaps);
        logic [NI-1:0] e;
        exp_q.push_back(exp_m);
        send_cmd(OP_SEARCH, '0, len);
        if (n > 0) send_pixels(n, gaps);
        wait_done(tag, (n > 0) ? 3 : 1);
        e = exp_q.pop_front();
        chk({tag, "_match"}, match, e);
        chk({tag, "_any"}, match_any, |e);
        chk({tag, "_idx"}, match_idx, exp_idx);
    endtask

    task automatic fill_a();
        buf_px[0] = 24'h0000FF;
        buf_px[1] = 24'h00FF00;
        buf_px[2] = 24'hFF0000;
        buf_px[3] = 24'h123456;
    endtask

    task automatic fill_b();
        buf_px[0] = 24'h111111;
        buf_px[1] = 24'h222222;
        buf_px[2] = 24'h333333;
        buf_px[3] = 24'h444444;
    endtask

    task automatic fill_16();
        for (int i = 0; i < 16; i++) buf_px[i] = 24'(32'h00A51C * (i + 3) + i);
    endtask

    initial begin
        int dc;
        reset         = 1'b0;
        tol           = 8'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_sel   = '0;
        bus.cmd_len   = '0;
        bus.px_valid  = 1'b0;
        bus.px_data   = '0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_px_ready", bus.px_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_match_any", match_any, 0);
        chk("rst_match_idx", match_idx, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        // empty CAM
        fill_a();
        do_search("empty", 4, 5'd4, 4'b0000, 2'd0, 1'b0);

        // slot0 = A, slot2 = B, with a held-off command check during LOAD
        send_cmd(OP_LOAD, 2'd0, 5'd4);
        @(negedge clk);
        chk("load_busy", busy, 1);
        chk("load_cmd_ready", bus.cmd_ready, 0);
        send_pixels(4, 1'b0);
        wait_done("load0", 1);
        fill_b();
        do_load("load2", 2'd2, 4, 5'd4, 1'b0);
        fill_a();
        do_search("srchA", 4, 5'd4, 4'b0001, 2'd0, 1'b0);

        do_load("load1", 2'd1, 4, 5'd4, 1'b0);
        do_search("srchA2", 4, 5'd4, 4'b0011, 2'd0, 1'b0);

        send_cmd(OP_INVAL, 2'd0, 5'd0);
        wait_done("inval0", 1);
        do_search("srchA3", 4, 5'd4, 4'b0010, 2'd1, 1'b0);
        do_search("len_mis", 3, 5'd3, 4'b0000, 2'd0, 1'b0);

        fill_b();
        do_search("srchB", 4, 5'd4, 4'b0100, 2'd2, 1'b0);
        send_cmd(OP_RSVD, 2'd3, 5'd7);
        wait_done("rsvd", 1);
        chk("hold_match", match, 4'b0100);
        chk("hold_idx", match_idx, 2);

        // pixels offered in IDLE are not accepted
        @(negedge clk);
        bus.px_valid = 1'b1;
        bus.px_data  = 24'hDEAD00;
        repeat (3) begin
            @(negedge clk);
            chk("idle_px_ready", bus.px_ready, 0);
        end
        bus.px_valid = 1'b0;
        chk("idle_busy", busy, 0);

        // zero-length commands
        do_search("len0_none", 0, 5'd0, 4'b0000, 2'd0, 1'b0);
        do_load("load3_len0", 2'd3, 0, 5'd0, 1'b0);
        do_search("len0_hit", 0, 5'd0, 4'b1000, 2'd3, 1'b0);

        // full-depth streams, gap-free then with random gaps
        fill_16();
        do_load("load3_16", 2'd3, 16, 5'd16, 1'b0);
        do_search("srch16", 16, 5'd16, 4'b1000, 2'd3, 1'b0);
        do_load("load3_16g", 2'd3, 16, 5'd16, 1'b1);
        do_search("srch16g", 16, 5'd16, 4'b1000, 2'd3, 1'b1);
        buf_px[15] = buf_px[15] ^ 24'h000001;
        do_search("near_miss", 16, 5'd16, 4'b0000, 2'd0, 1'b0);
        fill_16();

        // oversized lengths saturate to the slot depth
        do_load("load0_sat", 2'd0, 16, 5'd20, 1'b0);
        do_search("srch_sat", 16, 5'd31, 4'b1001, 2'd0, 1'b1);

        // single-pixel compare
        buf_px[0] = 24'h101010;
        do_load("load2_px", 2'd2, 1, 5'd1, 1'b0);
        do_search("exact", 1, 5'd1, 4'b0100, 2'd2, 1'b0);
`ifdef PIXEL_TOL_EN
        tol = 8'd2;
        buf_px[0] = 24'h121010;
        do_search("tol_in", 1, 5'd1, 4'b0100, 2'd2, 1'b0);
        buf_px[0] = 24'h131010;
        do_search("tol_out", 1, 5'd1, 4'b0000, 2'd0, 1'b0);
        tol = 8'd0;
`else
        buf_px[0] = 24'h101011;
        do_search("exact_miss", 1, 5'd1, 4'b0000, 2'd0, 1'b0);
`endif
        buf_px[0] = 24'h101010;
        do_search("exact_again", 1, 5'd1, 4'b0100, 2'd2, 1'b0);

        // reset in the middle of a search
        fill_a();
        send_cmd(OP_SEARCH, 2'd0, 5'd4);
        send_pixels(2, 1'b0);
        dc = done_cnt;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_match", match, 0);
        chk("midrst_state", dbg_state, IDLE);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_done", done_cnt, dc);
        chk("midrst_idle_busy", busy, 0);
        do_search("after_rst", 4, 5'd4, 4'b0000, 2'd0, 1'b0);
        do_search("after_rst_len0", 0, 5'd0, 4'b0000, 2'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
